// File: rtl/lsu_bus_master.sv
// Load/store unit bus master.
// Accepts one core request at a time, checks alignment, runs a single word
// access on a simple ready/valid bus and returns one response pulse with
// right-aligned, size-extended load data.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  // core request side
  input  logic        ReqVld,
  output logic        ReqRdy,
  input  logic        ReqWr,
  input  logic [31:0] ReqAddr,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqWData,
  // core response side
  output logic        RspVld,
  output logic [31:0] RspData,
  output logic        RspErr,
  // word-indexed memory bus
  output logic        RRdy,
  output logic [31:0] RAddr,
  output logic [31:0] RWData,
  output logic        RWEn,
  output logic [3:0]  RWStrobe,
  input  logic        RVld,
  input  logic [31:0] RData
);

  // Wait counter only needs to reach TIMEOUT-1; the final waiting edge aborts.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_e;

  // Size 3 is never legal; halves need even, words need 4-byte alignment.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << off;
      2'd1:    strb = 4'b0011 << {off[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the right-aligned store data into every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'd0:    lanes = {4{data[7:0]}};
      2'd1:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Move the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] ext;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    ext = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{16{sgn & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;

  logic          req_rdy_q, req_rdy_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rrdy_q, rrdy_d;
  logic [31:0]   raddr_q, raddr_d;
  logic [31:0]   rwdata_q, rwdata_d;
  logic          rwen_q, rwen_d;
  logic [3:0]    rwstrobe_q, rwstrobe_d;

  // State, latched request fields and every output are plain registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      req_rdy_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 32'h0000_0000;
      rsp_err_q  <= 1'b0;
      rrdy_q     <= 1'b0;
      raddr_q    <= 32'h0000_0000;
      rwdata_q   <= 32'h0000_0000;
      rwen_q     <= 1'b0;
      rwstrobe_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      req_rdy_q  <= req_rdy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rrdy_q     <= rrdy_d;
      raddr_q    <= raddr_d;
      rwdata_q   <= rwdata_d;
      rwen_q     <= rwen_d;
      rwstrobe_q <= rwstrobe_d;
    end
  end

  // Next state plus next output values; outputs are derived from the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    raddr_d    = raddr_q;
    rrdy_d     = 1'b0;
    rwen_d     = 1'b0;
    rwstrobe_d = 4'b0000;
    rwdata_d   = 32'h0000_0000;
    rsp_vld_d  = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        if (ReqVld && req_rdy_q) begin
          off_d  = ReqAddr[1:0];
          size_d = ReqSize;
          sgn_d  = ReqSigned;
          cnt_d  = '0;
          if (access_illegal(ReqSize, ReqAddr[1:0])) begin
            // Rejected without touching the bus.
            state_d   = RSP;
            rsp_vld_d = 1'b1;
            rsp_err_d = 1'b1;
          end else if (ReqWr) begin
            state_d    = WR;
            raddr_d    = {2'b00, ReqAddr[31:2]};
            rwen_d     = 1'b1;
            rwstrobe_d = store_strobe(ReqSize, ReqAddr[1:0]);
            rwdata_d   = store_lanes(ReqSize, ReqWData);
          end else begin
            state_d = RD;
            raddr_d = {2'b00, ReqAddr[31:2]};
            rrdy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (RVld) begin
          state_d    = RSP;
          rsp_vld_d  = 1'b1;
          rsp_data_d = load_extend(size_q, sgn_q, off_q, RData);
        end else if (cnt_q == CNT_LAST) begin
          // Responder never answered: abort; a late RVld is ignored outside RD.
          state_d   = RSP;
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          rrdy_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      WR: begin
        // The write is a single bus beat with no handshake.
        state_d   = RSP;
        rsp_vld_d = 1'b1;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_rdy_d = (state_d == IDLE);
  end

  assign ReqRdy   = req_rdy_q;
  assign RspVld   = rsp_vld_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;
  assign RRdy     = rrdy_q;
  assign RAddr    = raddr_q;
  assign RWData   = rwdata_q;
  assign RWEn     = rwen_q;
  assign RWStrobe = rwstrobe_q;

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles RRdy is held without RVld before the read is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port ReqVld, input, 1, core request valid.
REQ-005 SHALL have port ReqRdy, output, 1, request accepted when ReqVld and ReqRdy are both high at a clk edge.
REQ-006 SHALL have port ReqWr, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port ReqAddr, input, 32, byte address.
REQ-008 SHALL have port ReqSize, input, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have port ReqSigned, input, 1, sign-extend load data.
REQ-010 SHALL have port ReqWData, input, 32, store data, right-aligned.
REQ-011 SHALL have port RspVld, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port RspData, output, 32, extended load data; 0 for stores and errors.
REQ-013 SHALL have port RspErr, output, 1, qualifies RspVld; misaligned, illegal or timed out.
REQ-014 SHALL have port RRdy, output, 1, bus read request.
REQ-015 SHALL have port RAddr, output, 32, bus word address.
REQ-016 SHALL have port RWData, output, 32, bus write data.
REQ-017 SHALL have port RWEn, output, 1, bus write enable.
REQ-018 SHALL have port RWStrobe, output, 4, bus byte enables.
REQ-019 SHALL have port RVld, input, 1, responder read valid.
REQ-020 SHALL have port RData, input, 32, responder read data; valid only while RVld is high.

Function
REQ-021 SHALL use FSM states IDLE, RD, WR and RSP; ReqRdy SHALL be 1 only in IDLE.
REQ-022 SHALL, on acceptance, latch address, size, signed flag and data, and go to RSP with RspErr=1 if the access is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or ReqSize=3, with no bus activity.
REQ-023 SHALL drive all bus outputs from registers; RAddr = ReqAddr[31:2], i.e. the memory is word-indexed.
REQ-024 SHALL, for a legal load, enter RD: RRdy=1 from the cycle after acceptance, RAddr held stable until RVld is sampled high.
REQ-025 SHALL deassert RRdy on the same edge RVld is sampled high, capture RData, and go to RSP.
REQ-026 SHALL, for a legal store, enter WR for exactly one cycle: RWEn=1, RWStrobe = 0001<<a[1:0] (byte), 0011<<{a[1],0} (half) or 1111 (word), and RWData = lane-replicated data; then go to RSP.
REQ-027 SHALL never assert RRdy and RWEn in the same cycle.
REQ-028 SHALL, in RSP, assert RspVld for exactly one cycle, then return to IDLE.
REQ-029 SHALL, for loads, shift RspData right by 8*a[1:0], mask it to the access size, and sign-extend if ReqSigned else zero-extend.
REQ-030 SHALL define latency, with acceptance at edge N: error gives RspVld in cycle N+1; store gives RWEn in N+1 and RspVld in N+2; load gives RRdy from N+1 and RspVld in the cycle after RVld is sampled (N+3 with a 1-cycle responder).
REQ-031 SHALL count RD cycles with RVld low; on reaching TIMEOUT, drop RRdy and go to RSP with RspErr=1 and RspData=0.
REQ-032 SHALL ignore RVld outside RD (e.g. a late response after a timeout).
REQ-033 SHALL hold RspData and RspErr at 0 whenever RspVld is 0.

Reset
REQ-034 SHALL, while rstn=0, immediately force state IDLE and all outputs to 0 (ReqRdy to 0 as well); a pending request is discarded without a response.
REQ-035 SHALL set ReqRdy=1 on the first clk edge after rstn rises.

Verification
REQ-036 Load word: addr 0x0000_0400, mem[0x100]=0xDEADBEEF -> RAddr=0x100, RRdy high 2 cycles, RspVld with RspData=0xDEADBEEF, RspErr=0.
REQ-037 Signed byte load: addr 0x403, mem[0x100]=0x80112233 -> RspData=0xFFFFFF80; unsigned gives 0x00000080.
REQ-038 Store half: addr 0x012, data 0x0000ABCD -> one RWEn cycle, RAddr=0x4, RWStrobe=1100, RWData=0xABCDABCD; RspVld the next cycle; mem[0x4] bits 15:0 unchanged.
REQ-039 Misaligned word load at 0x401 -> RspVld with RspErr=1 in the cycle after acceptance; RRdy and RWEn stay 0.
REQ-040 Responder stuck with RVld=0, TIMEOUT=16 -> RRdy high exactly 16 cycles, then RspErr=1; an RVld pulse 3 cycles later produces no response.
REQ-041 rstn pulled low while in RD -> RRdy=0 without waiting for a clk edge, no RspVld, and ReqRdy=1 one edge after release.
